// File: rtl/piradip_axis_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter with a registered output stage.
// The grant is held until TLAST (or MAX_BURST beats) and the source index rides on m_tdest.
module piradip_axis_rr_arbiter #(
    parameter int N_IN      = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 0,
    parameter int ID_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_IN-1:0]       s_tvalid,
    output logic [N_IN-1:0]       s_tready,
    input  logic [N_IN*WIDTH-1:0] s_tdata,
    input  logic [N_IN-1:0]       s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [WIDTH-1:0]      m_tdata,
    output logic                  m_tlast,
    output logic [ID_W-1:0]       m_tdest,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]                 state;
    logic [ID_W-1:0]            last_ptr;
    logic [ID_W-1:0]            winner;
    logic [CNT_W-1:0]           beat_cnt;
    logic [N_IN-1:0][WIDTH-1:0] s_data_arr;
    logic                       accept;
    logic                       burst_end;
    logic                       beat_last;

    assign s_data_arr = s_tdata;

    // Index k steps past base, wrapping at N_IN (N_IN need not be a power of two).
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= N_IN) t = t - N_IN;
        return ID_W'(t);
    endfunction

    // Scan from the far end so the nearest requester after last_ptr overwrites the rest.
    always_comb begin
        winner = '0;
        for (int k = N_IN; k >= 1; k--) begin
            if (s_tvalid[rr_next(last_ptr, k)]) winner = rr_next(last_ptr, k);
        end
    end

    always_comb begin
        s_tready = '0;
        if (state == S_GRANT) s_tready[grant_id] = !m_tvalid || m_tready;
    end

    assign accept    = (state == S_GRANT) && s_tvalid[grant_id] && s_tready[grant_id];
    assign burst_end = (MAX_BURST != 0) && (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign beat_last = s_tlast[grant_id] || burst_end;
    assign busy      = (state == S_GRANT);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            last_ptr <= ID_W'(N_IN - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tdest  <= '0;
        end else begin
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_data_arr[grant_id];
                m_tlast  <= beat_last;
                m_tdest  <= grant_id;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (|s_tvalid) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        if (beat_last) begin
                            last_ptr <= grant_id;
                            state    <= S_IDLE;
                        end else if (MAX_BURST != 0) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
